// File: rtl/sat_accum_pkg.sv
// sat_accum_pkg
// Purpose : shared types and constant helpers for the saturating frame
//           accumulator (sat_accum_stage) and its adder (sat_add_acc).
// Contents: state_t     - frame FSM states
//           acc_max()   - largest positive value of an acc_w-bit signed word
//           acc_min()   - most negative value of an acc_w-bit signed word
//           cnt_width() - sample counter width, at least 1 bit even for N=1
package sat_accum_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int DEF_W         = 4;
  localparam int DEF_ACC_W     = 5;
  localparam int DEF_N_SAMPLES = 4;

  function automatic int acc_max(input int acc_w);
    return (1 << (acc_w - 1)) - 1;
  endfunction

  function automatic int acc_min(input int acc_w);
    return -(1 << (acc_w - 1));
  endfunction

  // $clog2(1) is 0, which would give a zero-width counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sat_accum_stage_if.sv
// sat_accum_stage_if
// Purpose : sample-in / frame-result-out handshake bundle of sat_accum_stage.
// Signals : in_valid/in_ready/in_data  - upstream sample stream (W-bit signed)
//           in_flush                   - close frame early (SAT_ACCUM_FLUSH_EN)
//           out_valid/out_ready        - frame result handshake
//           out_data                   - ACC_W-bit signed saturated frame sum
//           out_sat                    - saturation seen during the frame
// Modports: master - producer of samples / consumer of results
//           slave  - the accumulator stage itself
// Macro   : SAT_ACCUM_FLUSH_EN adds in_flush.
interface sat_accum_stage_if #(
  parameter int W     = 4,
  parameter int ACC_W = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
`ifdef SAT_ACCUM_FLUSH_EN
  logic             in_flush;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_sat;

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
`ifdef SAT_ACCUM_FLUSH_EN
    output in_flush,
`endif
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_sat
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
`ifdef SAT_ACCUM_FLUSH_EN
    input  in_flush,
`endif
    output out_valid,
    input  out_ready,
    output out_data,
    output out_sat
  );

endinterface

// File: rtl/sat_accum_stage_sat_add_acc.sv
// sat_add_acc
// Purpose : combinational signed saturating add of a W-bit sample onto an
//           ACC_W-bit accumulator (ACC_W >= W).
// Ports   : acc    in  ACC_W  current accumulator (signed)
//           sample in  W      new sample (signed)
//           sum    out ACC_W  clamped acc + sample
//           ovf    out 1      sum was clamped
module sat_add_acc
  import sat_accum_pkg::*;
#(
  parameter int W     = 4,
  parameter int ACC_W = 5
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [W-1:0]     sample,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(acc_max(ACC_W));
  localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(acc_min(ACC_W));

  logic [ACC_W:0] acc_ext;
  logic [ACC_W:0] smp_ext;
  logic [ACC_W:0] sum_ext;

  // Both operands fit in ACC_W bits, so one guard bit holds the exact sum;
  // overflow shows up as the guard bit disagreeing with the ACC_W-bit sign.
  always_comb begin
    acc_ext = {acc[ACC_W-1], acc};
    smp_ext = {{(ACC_W + 1 - W){sample[W-1]}}, sample};
    sum_ext = acc_ext + smp_ext;
    ovf     = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    sum     = sum_ext[ACC_W-1:0];
    if (ovf) begin
      sum = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

endmodule

// File: rtl/sat_accum_stage.sv
// sat_accum_stage
// Purpose : accumulates N_SAMPLES signed samples per frame with per-step
//           saturation and hands out one frame result per frame on a
//           valid/ready port with backpressure.
// Ports   : clk    in  1  rising-edge clock
//           rst_n  in  1  asynchronous active-low reset
//           bus    sat_accum_stage_if.slave (sample in, frame result out)
// Macro   : SAT_ACCUM_FLUSH_EN - an accepted sample with in_flush=1 closes
//           the frame early, including that sample.
//
// state | meaning
// ------+-------------------------------------------------------------
// ACCUM | taking samples, in_ready=1, accumulator updates on accept
// HOLD  | frame result presented, in_ready=0, waits for out_ready
module sat_accum_stage
  import sat_accum_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int N_SAMPLES = DEF_N_SAMPLES
) (
  input  logic               clk,
  input  logic               rst_n,
  sat_accum_stage_if.slave   bus
);

  localparam int               CNT_W    = cnt_width(N_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_sat_q, out_sat_d;

  logic             in_ready;
  logic             accept;
  logic             frame_end;
  logic [ACC_W-1:0] sum;
  logic             ovf;

  sat_add_acc #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_sat_add_acc (
    .acc    (acc_q),
    .sample (bus.in_data),
    .sum    (sum),
    .ovf    (ovf)
  );

  assign in_ready = (state_q == ACCUM);
  assign accept   = bus.in_valid & in_ready;

`ifdef SAT_ACCUM_FLUSH_EN
  assign frame_end = (cnt_q == CNT_LAST) | bus.in_flush;
`else
  assign frame_end = (cnt_q == CNT_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (frame_end) begin
            // Result takes the value including this sample; the running
            // state is cleared so the next frame starts fresh.
            out_data_d = sum;
            out_sat_d  = sat_q | ovf;
            acc_d      = '0;
            cnt_d      = '0;
            sat_d      = 1'b0;
            state_d    = HOLD;
          end else begin
            acc_d = sum;
            sat_d = sat_q | ovf;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_sat_accum_stage.sv
// tb_sat_accum_stage
// Purpose : self-checking bench for sat_accum_stage with directed frames
//           and randomized frames against a plain-integer frame model.
// Macro   : SAT_ACCUM_FLUSH_EN enables the early-close frames.
module tb_sat_accum_stage;

  localparam int W         = 4;
  localparam int ACC_W     = 5;
  localparam int N_SAMPLES = 4;
  localparam int MAX_V     = 15;
  localparam int MIN_V     = -16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

`ifdef SAT_ACCUM_FLUSH_EN
  bit flush_last_g;
`endif

  sat_accum_stage_if #(.W(W), .ACC_W(ACC_W)) bus ();

  sat_accum_stage #(
    .W         (W),
    .ACC_W     (ACC_W),
    .N_SAMPLES (N_SAMPLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Frame reference: running integer sum clamped to the ACC_W range after
  // every sample; saturation is sticky across the frame.
  task automatic model_frame(input int s[$], output int sum, output bit sat);
    int acc;
    acc = 0;
    sat = 1'b0;
    foreach (s[i]) begin
      acc = acc + s[i];
      if (acc > MAX_V) begin
        acc = MAX_V;
        sat = 1'b1;
      end else if (acc < MIN_V) begin
        acc = MIN_V;
        sat = 1'b1;
      end
    end
    sum = acc;
  endtask

  function automatic int data_s();
    return int'($signed(bus.out_data));
  endfunction

  task automatic run_frame(input string tag, input int s[$], input int bp);
    int exp_sum;
    bit exp_sat;
    int wait_cnt;
    model_frame(s, exp_sum, exp_sat);
    foreach (s[i]) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom);
        @(negedge clk);
      end
      wait_cnt = 0;
      while (!bus.in_ready && wait_cnt < 20) begin
        @(negedge clk);
        wait_cnt++;
      end
      if (wait_cnt >= 20) check_val({tag, " in_ready_timeout"}, 0, 1);
      if (i == s.size() - 1) check_val({tag, " valid_before_last"}, int'(bus.out_valid), 0);
      bus.in_valid = 1'b1;
      bus.in_data  = W'(s[i]);
`ifdef SAT_ACCUM_FLUSH_EN
      bus.in_flush = flush_last_g && (i == s.size() - 1);
`endif
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
`ifdef SAT_ACCUM_FLUSH_EN
    bus.in_flush = 1'b0;
`endif
    check_val({tag, " out_valid"}, int'(bus.out_valid), 1);
    check_val({tag, " out_data"},  data_s(), exp_sum);
    check_val({tag, " out_sat"},   int'(bus.out_sat), int'(exp_sat));
    check_val({tag, " in_ready_hold"}, int'(bus.in_ready), 0);
    // Offered samples during backpressure must not be taken.
    repeat (bp) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'($urandom);
      @(negedge clk);
      check_val({tag, " bp_valid"},    int'(bus.out_valid), 1);
      check_val({tag, " bp_data"},     data_s(), exp_sum);
      check_val({tag, " bp_sat"},      int'(bus.out_sat), int'(exp_sat));
      check_val({tag, " bp_in_ready"}, int'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_val({tag, " post_valid"},    int'(bus.out_valid), 0);
    check_val({tag, " post_in_ready"}, int'(bus.in_ready), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, " rst_out_valid"}, int'(bus.out_valid), 0);
    check_val({tag, " rst_out_data"},  data_s(), 0);
    check_val({tag, " rst_out_sat"},   int'(bus.out_sat), 0);
  endtask

  initial begin
    int q[$];
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef SAT_ACCUM_FLUSH_EN
    bus.in_flush  = 1'b0;
    flush_last_g  = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);
    check_val("por in_ready", int'(bus.in_ready), 1);

    q = {3, -2, 5, -1};   run_frame("mixed", q, 0);
    q = {7, 7, 7, 7};     run_frame("pos_clamp", q, 1);
    q = {-8, -8, -8, -8}; run_frame("neg_clamp", q, 0);
    q = {7, 7, 7, -8};    run_frame("sticky", q, 2);
    q = {-3, 6, 2, 4};    run_frame("bp5", q, 5);
    q = {1, 1, 1, 1};     run_frame("after_bp", q, 0);

    // Reset mid-frame: the partial 5+5 must be discarded.
    bus.in_valid = 1'b1;
    bus.in_data  = W'(5);
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_frame");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("mid_frame in_ready", int'(bus.in_ready), 1);
    q = {1, 2, 3, 4};     run_frame("after_rst", q, 0);

    // Reset while holding a result.
    bus.in_valid = 1'b1;
    bus.in_data  = W'(7);
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
    check_val("hold_rst pre_valid", int'(bus.out_valid), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("hold_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("hold_rst in_ready", int'(bus.in_ready), 1);
    q = {-2, -2, 3, 0};   run_frame("after_hold_rst", q, 1);

`ifdef SAT_ACCUM_FLUSH_EN
    flush_last_g = 1'b1;
    q = {2, 3};           run_frame("flush", q, 0);
    q = {-8};             run_frame("flush_one", q, 1);
    for (int f = 0; f < 10; f++) begin
      q = {};
      repeat ($urandom_range(1, N_SAMPLES)) q.push_back(int'($urandom_range(0, 15)) - 8);
      run_frame($sformatf("rnd_flush%0d", f), q, int'($urandom_range(0, 2)));
    end
    flush_last_g = 1'b0;
`endif

    for (int f = 0; f < 25; f++) begin
      q = {};
      repeat (N_SAMPLES) q.push_back(int'($urandom_range(0, 15)) - 8);
      run_frame($sformatf("rnd%0d", f), q, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
